inst_rom_loader: RTL and testbench

Word-addressed instruction memory that sits directly upstream of the CPU core and drives its instruction-fetch port: it receives the PC address and chip-enable, and returns the instruction word. Before execution, the memory is programmed over a byte-serial valid/ready load interface. While loading, the block holds the core in reset; when loading completes, it releases the core.

---
 rtl/inst_rom_loader.sv | 142 ++++++++++++++
 tb/tb_inst_rom_loader.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/inst_rom_loader.sv
// Instruction memory for the core's fetch port, programmed over a byte-serial
// valid/ready interface; the core is held in reset until a load session completes.
module inst_rom_loader #(
   parameter int ADDR_WIDTH = 10
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  rom_ce_i,
   input  logic [31:0]           rom_addr_i,
   output logic [31:0]           rom_data_o,
   input  logic                  ld_start_i,
   input  logic [ADDR_WIDTH:0]   ld_len_i,
   input  logic                  ld_valid_i,
   input  logic [7:0]            ld_byte_i,
   output logic                  ld_ready_o,
   output logic [ADDR_WIDTH:0]   ld_cnt_o,
   output logic                  cpu_rst_o
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_LOAD = 2'd1;
   localparam logic [1:0] ST_RUN  = 2'd2;

   localparam logic [ADDR_WIDTH:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};
   localparam logic [ADDR_WIDTH:0] CNT_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};
   localparam logic [ADDR_WIDTH-1:0] PTR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

   logic [1:0]            state_q, state_d;
   logic [1:0]            byte_cnt_q, byte_cnt_d;
   logic [ADDR_WIDTH-1:0] word_ptr_q, word_ptr_d;
   logic [ADDR_WIDTH:0]   ld_cnt_q, ld_cnt_d;
   logic [ADDR_WIDTH:0]   len_q, len_d;
   logic [23:0]           asm_q, asm_d;
   logic                  ld_ready_s;
   logic                  accept_s;
   logic                  we_s;
   logic [ADDR_WIDTH:0]   cnt_inc_s;

   logic [31:0] mem [0:(1 << ADDR_WIDTH)-1];

   // Ready is withheld when the session is already complete (covers len = 0).
   assign ld_ready_s = (state_q == ST_LOAD) && (ld_cnt_q != len_q);
   assign accept_s   = ld_valid_i & ld_ready_s;
   assign cnt_inc_s  = ld_cnt_q + CNT_ONE;

   // Next-state and load datapath.
   always_comb begin
      state_d    = state_q;
      byte_cnt_d = byte_cnt_q;
      word_ptr_d = word_ptr_q;
      ld_cnt_d   = ld_cnt_q;
      len_d      = len_q;
      asm_d      = asm_q;
      we_s       = 1'b0;
      case (state_q)
         ST_IDLE, ST_RUN: begin
            if (ld_start_i) begin
               state_d    = ST_LOAD;
               len_d      = (ld_len_i > DEPTH) ? DEPTH : ld_len_i;
               word_ptr_d = {ADDR_WIDTH{1'b0}};
               byte_cnt_d = 2'd0;
               ld_cnt_d   = {(ADDR_WIDTH+1){1'b0}};
               asm_d      = 24'd0;
            end else begin
               state_d = state_q;
            end
         end
         ST_LOAD: begin
            if (ld_cnt_q == len_q) begin
               state_d = ST_RUN;
            end else if (accept_s) begin
               if (byte_cnt_q == 2'd3) begin
                  we_s       = 1'b1;
                  word_ptr_d = word_ptr_q + PTR_ONE;
                  ld_cnt_d   = cnt_inc_s;
                  byte_cnt_d = 2'd0;
                  if (cnt_inc_s == len_q) begin
                     state_d = ST_RUN;
                  end else begin
                     state_d = ST_LOAD;
                  end
               end else begin
                  byte_cnt_d = byte_cnt_q + 2'd1;
                  case (byte_cnt_q)
                     2'd0:    asm_d[23:16] = ld_byte_i;
                     2'd1:    asm_d[15:8]  = ld_byte_i;
                     2'd2:    asm_d[7:0]   = ld_byte_i;
                     default: asm_d        = asm_q;
                  endcase
               end
            end else begin
               state_d = ST_LOAD;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Control and load-session registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         byte_cnt_q <= 2'd0;
         word_ptr_q <= {ADDR_WIDTH{1'b0}};
         ld_cnt_q   <= {(ADDR_WIDTH+1){1'b0}};
         len_q      <= {(ADDR_WIDTH+1){1'b0}};
         asm_q      <= 24'd0;
      end else begin
         state_q    <= state_d;
         byte_cnt_q <= byte_cnt_d;
         word_ptr_q <= word_ptr_d;
         ld_cnt_q   <= ld_cnt_d;
         len_q      <= len_d;
         asm_q      <= asm_d;
      end
   end

   // Memory write port; contents deliberately survive rst.
   always_ff @(posedge clk) begin
      if (we_s) begin
         mem[word_ptr_q] <= {asm_q, ld_byte_i};
      end
   end

   // Asynchronous fetch, gated to zero unless the core is running.
   always_comb begin
      if ((state_q == ST_RUN) && rom_ce_i) begin
         rom_data_o = mem[rom_addr_i[ADDR_WIDTH+1:2]];
      end else begin
         rom_data_o = 32'd0;
      end
   end

   wire unused_addr_bits = ^{rom_addr_i[31:ADDR_WIDTH+2], rom_addr_i[1:0]};

   assign ld_ready_o = ld_ready_s;
   assign ld_cnt_o   = ld_cnt_q;
   assign cpu_rst_o  = (state_q != ST_RUN);

endmodule

// File: tb/tb_inst_rom_loader.sv
// Directed bench for inst_rom_loader; expected values go through a scoreboard queue.
module tb_inst_rom_loader;

   localparam int AW = 10;

   logic          clk = 1'b0;
   logic          rst;
   logic          rom_ce_i;
   logic [31:0]   rom_addr_i;
   logic [31:0]   rom_data_o;
   logic          ld_start_i;
   logic [AW:0]   ld_len_i;
   logic          ld_valid_i;
   logic [7:0]    ld_byte_i;
   logic          ld_ready_o;
   logic [AW:0]   ld_cnt_o;
   logic          cpu_rst_o;

   logic [31:0] exp_q[$];
   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   inst_rom_loader #(.ADDR_WIDTH(AW)) dut (
      .clk        (clk),
      .rst        (rst),
      .rom_ce_i   (rom_ce_i),
      .rom_addr_i (rom_addr_i),
      .rom_data_o (rom_data_o),
      .ld_start_i (ld_start_i),
      .ld_len_i   (ld_len_i),
      .ld_valid_i (ld_valid_i),
      .ld_byte_i  (ld_byte_i),
      .ld_ready_o (ld_ready_o),
      .ld_cnt_o   (ld_cnt_o),
      .cpu_rst_o  (cpu_rst_o)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs);
      logic [31:0] e;
      n_cmp++;
      if (exp_q.size() == 0) begin
         n_err++;
         $error("FAIL %s: scoreboard empty, observed %h", tag, obs);
      end else begin
         e = exp_q.pop_front();
         assert (obs === e) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, e);
         end
      end
   endtask

   task automatic expect_val(input string tag, input logic [31:0] obs, input logic [31:0] e);
      exp_q.push_back(e);
      check(tag, obs);
   endtask

   task automatic rd(input string tag, input logic [31:0] addr, input logic [31:0] e);
      rom_ce_i   = 1'b1;
      rom_addr_i = addr;
      exp_q.push_back(e);
      #1;
      check(tag, rom_data_o);
   endtask

   task automatic start(input logic [AW:0] len);
      ld_start_i = 1'b1;
      ld_len_i   = len;
      tick();
      ld_start_i = 1'b0;
      ld_len_i   = 11'h555;
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      int t;
      for (int g = 0; g < gap; g++) begin
         ld_valid_i = 1'b0;
         ld_byte_i  = 8'($urandom_range(255));
         tick();
      end
      ld_valid_i = 1'b1;
      ld_byte_i  = b;
      t = 0;
      while (!ld_ready_o && t < 50) begin
         tick();
         t++;
      end
      if (!ld_ready_o) begin
         n_cmp++;
         n_err++;
         $error("FAIL ready_timeout: observed ready %b expected 1", ld_ready_o);
      end
      tick();
      ld_valid_i = 1'b0;
      ld_byte_i  = 8'($urandom_range(255));
   endtask

   task automatic send_word(input logic [31:0] w, input bit stall);
      for (int k = 3; k >= 0; k--) begin
         send_byte(w[8*k +: 8], stall ? ((k % 2) + int'($urandom_range(3, 1))) : 0);
      end
   endtask

   initial begin
      rst        = 1'b1;
      rom_ce_i   = 1'b1;
      rom_addr_i = 32'd0;
      ld_start_i = 1'b0;
      ld_len_i   = '0;
      ld_valid_i = 1'b0;
      ld_byte_i  = 8'd0;

      // 1: reset
      tick();
      tick();
      expect_val("rst_cpu_rst", {31'd0, cpu_rst_o}, 32'd1);
      expect_val("rst_ready", {31'd0, ld_ready_o}, 32'd0);
      expect_val("rst_cnt", {21'd0, ld_cnt_o}, 32'd0);
      rd("rst_data", 32'h0, 32'h0);
      rst = 1'b0;
      tick();
      expect_val("idle_cpu_rst", {31'd0, cpu_rst_o}, 32'd1);
      rd("idle_data", 32'h0, 32'h0);

      // 2: back-to-back two-word load
      start(11'd2);
      expect_val("load_ready", {31'd0, ld_ready_o}, 32'd1);
      expect_val("load_cpu_rst", {31'd0, cpu_rst_o}, 32'd1);
      send_word(32'h34011100, 1'b0);
      expect_val("mid_cnt", {21'd0, ld_cnt_o}, 32'd1);
      expect_val("mid_cpu_rst", {31'd0, cpu_rst_o}, 32'd1);
      send_word(32'h34020020, 1'b0);
      expect_val("s2_cpu_rst", {31'd0, cpu_rst_o}, 32'd0);
      expect_val("s2_ready", {31'd0, ld_ready_o}, 32'd0);
      expect_val("s2_cnt", {21'd0, ld_cnt_o}, 32'd2);
      rd("s2_w0", 32'h0, 32'h34011100);
      rd("s2_w1", 32'h4, 32'h34020020);

      // 4: chip enable and address aliasing
      rom_ce_i = 1'b0;
      exp_q.push_back(32'h0);
      #1;
      check("ce_off", rom_data_o);
      rd("alias_1003", 32'h1003, 32'h34011100);
      rd("alias_1006", 32'h1006, 32'h34020020);
      rd("alias_hi", 32'hFFFF_F006, 32'h34020020);
      tick();
      expect_val("run_cnt_hold", {21'd0, ld_cnt_o}, 32'd2);

      // overwrite with different data so scenario 3 must really rewrite
      start(11'd2);
      rd("reload_gated", 32'h0, 32'h0);
      send_word(32'hDEADBEEF, 1'b0);
      send_word(32'hCAFEF00D, 1'b0);
      rd("ovr_w0", 32'h0, 32'hDEADBEEF);

      // 3: same load with gaps and stalls
      start(11'd2);
      send_word(32'h34011100, 1'b1);
      expect_val("s3_mid_cpu_rst", {31'd0, cpu_rst_o}, 32'd1);
      send_word(32'h34020020, 1'b1);
      expect_val("s3_cpu_rst", {31'd0, cpu_rst_o}, 32'd0);
      expect_val("s3_cnt", {21'd0, ld_cnt_o}, 32'd2);
      rd("s3_w0", 32'h0, 32'h34011100);
      rd("s3_w1", 32'h4, 32'h34020020);

      // 5: reset in the middle of a session
      start(11'd2);
      send_byte(8'hAA, 0);
      send_byte(8'hBB, 0);
      send_byte(8'hCC, 0);
      send_byte(8'hDD, 0);
      send_byte(8'hEE, 0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      expect_val("s5_rst_cpu_rst", {31'd0, cpu_rst_o}, 32'd1);
      expect_val("s5_rst_ready", {31'd0, ld_ready_o}, 32'd0);
      expect_val("s5_rst_cnt", {21'd0, ld_cnt_o}, 32'd0);
      start(11'd1);
      send_word(32'h11223344, 1'b0);
      expect_val("s5_cpu_rst", {31'd0, cpu_rst_o}, 32'd0);
      rd("s5_w0", 32'h0, 32'h11223344);
      rd("s5_w1_kept", 32'h4, 32'h34020020);

      // 6a: zero length
      ld_valid_i = 1'b1;
      ld_byte_i  = 8'h99;
      start(11'd0);
      ld_valid_i = 1'b1;
      ld_byte_i  = 8'h99;
      expect_val("len0_ready", {31'd0, ld_ready_o}, 32'd0);
      tick();
      ld_valid_i = 1'b0;
      expect_val("len0_cpu_rst", {31'd0, cpu_rst_o}, 32'd0);
      expect_val("len0_cnt", {21'd0, ld_cnt_o}, 32'd0);
      rd("len0_w0", 32'h0, 32'h11223344);

      // 6b: oversize length clamps to full depth
      start(11'h7FF);
      for (int i = 0; i < 4095; i++) begin
         send_byte(8'(i), 0);
      end
      expect_val("full_pre_cpu_rst", {31'd0, cpu_rst_o}, 32'd1);
      expect_val("full_pre_cnt", {21'd0, ld_cnt_o}, 32'd1023);
      send_byte(8'hFF, 0);
      expect_val("full_cpu_rst", {31'd0, cpu_rst_o}, 32'd0);
      expect_val("full_cnt", {21'd0, ld_cnt_o}, 32'd1024);
      rd("full_w0", 32'h0, 32'h00010203);
      rd("full_w1", 32'h4, 32'h04050607);
      rd("full_w1023", 32'hFFC, 32'hFCFDFEFF);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
